// File: rtl/apb_completer_regs_if.sv
// APB4 completer-side bus bundle.
// The requester drives the address/control/data; the completer drives the response.
interface apb_completer_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    pnse;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, pnse, psel, penable,
    output pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, pnse, psel, penable,
    input  pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_completer_regs.sv
// APB4 completer for a bank of word registers with byte strobes,
// wait states, error decode and a local hardware write port.
module apb_completer_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int OFFS = $clog2(BYTES),
  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         pclk,
  input  logic                         preset,
  apb_completer_regs_if.slave          apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse,
  input  logic                         hw_we,
  input  logic [IDXW-1:0]              hw_idx,
  input  logic [DATA_WIDTH-1:0]        hw_din
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LOMASK =
    ADDR_WIDTH'(BYTES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [IDXW-1:0]       r_idx;
  logic                  r_write;
  logic [BYTES-1:0]      r_strb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [NUM_REGS-1:0]   r_pulse;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDXW-1:0]       w_idx;
  logic                  w_range_err;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_ready;
  logic                  w_commit;
  logic                  w_unused;

  assign w_unused = &{1'b0, apb.pprot, apb.pnse};

  assign w_off  = apb.paddr - BASE_ADDR;
  assign w_word = w_off >> OFFS;
  assign w_idx  = w_word[IDXW-1:0];

  assign w_range_err = (apb.paddr < BASE_ADDR) ||
                       (w_word >= ADDR_WIDTH'(NUM_REGS));

  // RO lookup only matters when the index is in range
  always_comb begin
    w_err = 1'b0;
    if ((apb.paddr & LOMASK) != '0) w_err = 1'b1;
    if (w_range_err) w_err = 1'b1;
    else if (apb.pwrite && RO_MASK[w_idx]) w_err = 1'b1;
    if (!apb.pwrite && (apb.pstrb != '0)) w_err = 1'b1;
  end

  assign w_setup  = (r_state == S_IDLE) && apb.psel && !apb.penable;
  assign w_ready  = (r_state == S_ACCESS) && (r_cnt == WC);
  assign w_commit = w_ready && apb.psel && apb.penable &&
                    r_write && !r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_setup) w_next = S_ACCESS;
      S_ACCESS: begin
        if (!apb.psel) w_next = S_IDLE;
        else if (w_ready && apb.penable) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_strb  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_pulse <= '0;
    end else begin
      r_state <= w_next;
      r_pulse <= '0;
      if (w_commit) r_pulse[r_idx] <= 1'b1;
      if (w_setup) begin
        r_idx   <= w_idx;
        r_write <= apb.pwrite;
        r_strb  <= apb.pstrb;
        r_wdata <= apb.pwdata;
        r_err   <= w_err;
        r_cnt   <= '0;
      end else if (r_state == S_ACCESS && r_cnt < WC) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // APB strobed bytes are assigned last so they win over hw_din
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (hw_we && hw_idx == IDXW'(i))
            r_regs[i][b*8 +: 8] <= hw_din[b*8 +: 8];
          if (w_commit && r_idx == IDXW'(i) && r_strb[b])
            r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign apb.pready  = w_ready;
  assign apb.pslverr = w_ready && r_err;
  assign apb.prdata  = (w_ready && !r_err && !r_write) ?
                       r_regs[r_idx] : '0;

  assign wr_pulse = r_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench for apb_completer_regs: three instances cover
// zero/three/five wait states, RO register 0 and the hw port.
module tb_apb_completer_regs;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        penable = 1'b0;
  logic [2:0]  sel = '0;
  logic        hw_we = 1'b0;
  logic [3:0]  hw_idx = '0;
  logic [31:0] hw_din = '0;

  logic [511:0] q_a, q_b, q_c;
  logic [15:0]  wp_a, wp_b, wp_c;

  int n_pass = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  apb_completer_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_a ();
  apb_completer_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_b ();
  apb_completer_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_c ();

  assign if_a.paddr = paddr;   assign if_b.paddr = paddr;   assign if_c.paddr = paddr;
  assign if_a.pwrite = pwrite; assign if_b.pwrite = pwrite; assign if_c.pwrite = pwrite;
  assign if_a.pwdata = pwdata; assign if_b.pwdata = pwdata; assign if_c.pwdata = pwdata;
  assign if_a.pstrb = pstrb;   assign if_b.pstrb = pstrb;   assign if_c.pstrb = pstrb;
  assign if_a.penable = penable;
  assign if_b.penable = penable;
  assign if_c.penable = penable;
  assign if_a.psel = sel[0];
  assign if_b.psel = sel[1];
  assign if_c.psel = sel[2];
  assign if_a.pprot = 3'b0; assign if_b.pprot = 3'b0; assign if_c.pprot = 3'b0;
  assign if_a.pnse = 1'b0;  assign if_b.pnse = 1'b0;  assign if_c.pnse = 1'b0;

  apb_completer_regs #(.WAIT_CYCLES(0), .RO_MASK(16'h0001)) u_a (
    .pclk(clk), .preset(preset), .apb(if_a), .reg_q(q_a),
    .wr_pulse(wp_a), .hw_we(hw_we), .hw_idx(hw_idx), .hw_din(hw_din));

  apb_completer_regs #(.WAIT_CYCLES(3)) u_b (
    .pclk(clk), .preset(preset), .apb(if_b), .reg_q(q_b),
    .wr_pulse(wp_b), .hw_we(1'b0), .hw_idx(4'd0), .hw_din(32'd0));

  apb_completer_regs #(.WAIT_CYCLES(5)) u_c (
    .pclk(clk), .preset(preset), .apb(if_c), .reg_q(q_c),
    .wr_pulse(wp_c), .hw_we(1'b0), .hw_idx(4'd0), .hw_din(32'd0));

  function automatic logic rdy(int d);
    case (d)
      0: return if_a.pready;
      1: return if_b.pready;
      default: return if_c.pready;
    endcase
  endfunction

  function automatic logic [31:0] rdat(int d);
    case (d)
      0: return if_a.prdata;
      1: return if_b.prdata;
      default: return if_c.prdata;
    endcase
  endfunction

  function automatic logic serr(int d);
    case (d)
      0: return if_a.pslverr;
      1: return if_b.pslverr;
      default: return if_c.pslverr;
    endcase
  endfunction

  function automatic logic [15:0] wpl(int d);
    case (d)
      0: return wp_a;
      1: return wp_b;
      default: return wp_c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err,
                      output int waits, output logic [15:0] p1,
                      output logic [15:0] p0);
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    penable = 1'b0; sel = 3'b0; sel[d] = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (!rdy(d) && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    rd = rdat(d);
    err = serr(d);
    @(posedge clk); #1;
    sel = 3'b0; penable = 1'b0;
    p1 = wpl(d);
    @(posedge clk); #1;
    p0 = wpl(d);
  endtask

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vt[13];

  logic [31:0] rd;
  logic        er;
  int          wt;
  logic [15:0] p1, p0;
  bit          seen;

  initial begin
    vt[0]  = '{"wr08",    1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 0, 16'h0004};
    vt[1]  = '{"rd08",    0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 0, 16'h0};
    vt[2]  = '{"wr04",    1, 32'h04, 32'h11223344, 4'hF, 32'h0, 0, 16'h0002};
    vt[3]  = '{"wr04p",   1, 32'h04, 32'hAABBCCDD, 4'h5, 32'h0, 0, 16'h0002};
    vt[4]  = '{"rd04p",   0, 32'h04, 32'h0,        4'h0, 32'h11BB33DD, 0, 16'h0};
    vt[5]  = '{"rd40",    0, 32'h40, 32'h0,        4'h0, 32'h0, 1, 16'h0};
    vt[6]  = '{"wr06",    1, 32'h06, 32'h55555555, 4'hF, 32'h0, 1, 16'h0};
    vt[7]  = '{"wrro",    1, 32'h00, 32'h77777777, 4'hF, 32'h0, 1, 16'h0};
    vt[8]  = '{"rdstrb",  0, 32'h08, 32'h0,        4'h1, 32'h0, 1, 16'h0};
    vt[9]  = '{"rd00",    0, 32'h00, 32'h0,        4'h0, 32'h0, 0, 16'h0};
    vt[10] = '{"rd08b",   0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 0, 16'h0};
    vt[11] = '{"wr3c",    1, 32'h3C, 32'h5A5A5A5A, 4'hF, 32'h0, 0, 16'h8000};
    vt[12] = '{"rd3c",    0, 32'h3C, 32'h0,        4'h0, 32'h5A5A5A5A, 0, 16'h0};

    repeat (3) @(posedge clk);
    #1 preset = 1'b0;

    chk("rst_ready", {31'b0, if_a.pready}, 32'h0);
    chk("rst_prdata", if_a.prdata, 32'h0);
    chk("rst_slverr", {31'b0, if_a.pslverr}, 32'h0);
    chk("rst_pulse", {16'b0, wp_a}, 32'h0);
    chk("rst_regs_a", {31'b0, |q_a}, 32'h0);
    chk("rst_ready_c", {31'b0, if_c.pready}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb,
           rd, er, wt, p1, p0);
      chk({vt[i].name, "_waits"}, wt, 32'd0);
      chk({vt[i].name, "_err"}, {31'b0, er}, {31'b0, vt[i].exp_err});
      if (!vt[i].wr) chk({vt[i].name, "_rd"}, rd, vt[i].exp_rd);
      chk({vt[i].name, "_pulse"}, {16'b0, p1}, {16'b0, vt[i].exp_pulse});
      chk({vt[i].name, "_pulse_off"}, {16'b0, p0}, 32'h0);
    end
    chk("ro_reg0_kept", q_a[31:0], 32'h0);
    chk("reg2_kept", q_a[95:64], 32'hDEADBEEF);

    // penable without setup in IDLE starts nothing
    @(posedge clk); #1;
    paddr = 32'h08; pwrite = 1'b0; pstrb = '0;
    sel = 3'b001; penable = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if_a.pready) seen = 1'b1;
    end
    sel = 3'b0; penable = 1'b0;
    chk("penable_idle", {31'b0, seen}, 32'h0);

    // hw port writes an RO register and a plain one
    @(posedge clk); #1;
    hw_we = 1'b1; hw_idx = 4'd0; hw_din = 32'h00000077;
    @(posedge clk); #1;
    hw_idx = 4'd5; hw_din = 32'hCAFEF00D;
    @(posedge clk); #1;
    hw_we = 1'b0;
    chk("hw_reg0", q_a[31:0], 32'h00000077);
    chk("hw_reg5", q_a[191:160], 32'hCAFEF00D);
    chk("hw_nopulse", {16'b0, wp_a}, 32'h0);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, rd, er, wt, p1, p0);
    chk("rd_hw_reg0", rd, 32'h00000077);

    // APB commit colliding with hw write on reg3
    @(posedge clk); #1;
    paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hFFFFFFFF;
    pstrb = 4'b0011; sel = 3'b001; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    hw_we = 1'b1; hw_idx = 4'd3; hw_din = 32'h12345678;
    chk("coll_ready", {31'b0, if_a.pready}, 32'h1);
    @(posedge clk); #1;
    hw_we = 1'b0; sel = 3'b0; penable = 1'b0;
    chk("coll_reg3", q_a[127:96], 32'h1234FFFF);
    chk("coll_pulse", {16'b0, wp_a}, 32'h0008);

    // three wait states on a fresh register
    xfer(1, 0, 32'h04, 32'h0, 4'h0, rd, er, wt, p1, p0);
    chk("b_waits", wt, 32'd3);
    chk("b_rd", rd, 32'h0);
    chk("b_err", {31'b0, er}, 32'h0);

    // psel dropped during the access phase: no commit
    @(posedge clk); #1;
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'hA5A5A5A5;
    pstrb = 4'hF; sel = 3'b100; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1 sel = 3'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if_c.pready || wp_c != 16'h0) seen = 1'b1;
    end
    chk("abort_activity", {31'b0, seen}, 32'h0);
    chk("abort_reg2", q_c[95:64], 32'h0);

    // reset in the middle of a five-wait write
    @(posedge clk); #1;
    paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hFFFFFFFF;
    pstrb = 4'hF; sel = 3'b100; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1 preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    chk("rst_mid_ready", {31'b0, if_c.pready}, 32'h0);
    chk("rst_mid_reg1", q_c[63:32], 32'h0);
    chk("rst_mid_pulse", {16'b0, wp_c}, 32'h0);
    sel = 3'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if_c.pready || q_c[63:32] != 32'h0) seen = 1'b1;
    end
    chk("rst_mid_quiet", {31'b0, seen}, 32'h0);

    xfer(2, 0, 32'h04, 32'h0, 4'h0, rd, er, wt, p1, p0);
    chk("c_rd_waits", wt, 32'd5);
    chk("c_rd", rd, 32'h0);
    chk("c_rd_err", {31'b0, er}, 32'h0);

    xfer(2, 1, 32'h04, 32'h0BADF00D, 4'hF, rd, er, wt, p1, p0);
    chk("c_wr_waits", wt, 32'd5);
    chk("c_wr_pulse", {16'b0, p1}, 32'h0002);
    xfer(2, 0, 32'h04, 32'h0, 4'h0, rd, er, wt, p1, p0);
    chk("c_rd2", rd, 32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
